// File: rtl/seg_scan_driver_if.sv
// Digit/segment bundle between the time-counter side and the 7-segment scanner.
// The master drives the six BCD digits; the slave (scanner) drives seg/dp/an.
interface seg_scan_driver_if;
    logic [3:0] S0;
    logic [3:0] S1;
    logic [3:0] M0;
    logic [3:0] M1;
    logic [3:0] H0;
    logic [3:0] H1;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;

    modport master (
        output S0, S1, M0, M1, H0, H1,
        input  seg, dp, an
    );

    modport slave (
        input  S0, S1, M0, M1, H0, H1,
        output seg, dp, an
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 6-digit 7-segment scanner with frame-coherent digit snapshot.
// Optional build macro SEG_SCAN_COLON_BLINK_EN: separator dots blink with seconds units.
module seg_scan_driver #(
    parameter int SCAN_DIV       = 50,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic               CLOCK,
    input  logic               rst,
    seg_scan_driver_if.slave   bus
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [13:0] UNLIT_PINS = SEG_ACTIVE_LOW ? 14'h3FFF : 14'h0000;

    logic [PRE_W-1:0] pre_p0;
    logic [2:0]       idx_p0;
    logic [5:0][3:0]  shadow_p0;
    logic             init;

    logic             tick;
    logic             blank;
    logic             sep_en;
    logic [3:0]       cur_digit;
    logic [5:0]       an_lit;
    logic [6:0]       seg_lit;
    logic             dp_lit;

    logic [6:0]       seg_p1;
    logic             dp_p1;
    logic [5:0]       an_p1;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Maps logical "lit" to pin level for {an, seg, dp}.
    function automatic logic [13:0] to_pins(input logic [13:0] lit);
        return SEG_ACTIVE_LOW ? ~lit : lit;
    endfunction

    assign tick  = (pre_p0 == PRE_W'(SCAN_DIV - 1));
    assign blank = (int'(pre_p0) < BLANK_CYCLES);

    // Stage p0: prescaler, slot index and digit shadow
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            pre_p0    <= '0;
            idx_p0    <= '0;
            shadow_p0 <= '0;
            init      <= 1'b1;
        end else begin
            pre_p0 <= tick ? '0 : pre_p0 + PRE_W'(1);
            if (tick) begin
                idx_p0 <= (idx_p0 == 3'd5) ? 3'd0 : idx_p0 + 3'd1;
            end
            if (init || (tick && idx_p0 == 3'd5)) begin
                shadow_p0 <= {bus.H1, bus.H0, bus.M1, bus.M0, bus.S1, bus.S0};
            end
            init <= 1'b0;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        case (idx_p0)
            3'd0:    cur_digit = shadow_p0[0];
            3'd1:    cur_digit = shadow_p0[1];
            3'd2:    cur_digit = shadow_p0[2];
            3'd3:    cur_digit = shadow_p0[3];
            3'd4:    cur_digit = shadow_p0[4];
            3'd5:    cur_digit = shadow_p0[5];
            default: cur_digit = 4'd0;
        endcase
    end

`ifdef SEG_SCAN_COLON_BLINK_EN
    assign sep_en = ~shadow_p0[0][0];
`else
    assign sep_en = 1'b1;
`endif

    always_comb begin
        an_lit  = '0;
        seg_lit = '0;
        dp_lit  = 1'b0;
        if (!blank) begin
            an_lit = 6'b000001 << idx_p0;
            // H1 blanks its segments on zero but keeps its enable for even duty
            if (!(idx_p0 == 3'd5 && cur_digit == 4'd0)) begin
                seg_lit = seg_decode(cur_digit);
            end
            dp_lit = sep_en && (idx_p0 == 3'd2 || idx_p0 == 3'd4);
        end
    end

    // Stage p1: registered pin outputs, one cycle behind pre/idx
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            {an_p1, seg_p1, dp_p1} <= UNLIT_PINS;
        end else begin
            {an_p1, seg_p1, dp_p1} <= to_pins({an_lit, seg_lit, dp_lit});
        end
    end

    assign bus.seg = seg_p1;
    assign bus.dp  = dp_p1;
    assign bus.an  = an_p1;

endmodule
